tdc_burst_acc: RTL and testbench



---
 rtl/tdc_burst_acc.sv | 171 +++++++++++++++++
 tb/tb_tdc_burst_acc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tdc_burst_acc.sv
// tdc_burst_acc: per-burst Hamming-weight accumulator (sum/min/max) over
// 2^LOG_SAMPLES enabled samples of one selected TDC capture channel.
// Optional build macro TDC_BUBBLE_FIX_EN adds 3-input majority bubble
// correction on the selected word ahead of stage 1.
module tdc_burst_acc #(
    parameter int N           = 64,
    parameter int NCH         = 2,
    parameter int LOG_SAMPLES = 4,
    localparam int HW_W       = $clog2(N) + 1,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int SUM_W      = HW_W + LOG_SAMPLES
) (
    input  logic               clk_capture,
    input  logic               rst,
    input  logic               en,
    input  logic [NCH*N-1:0]   capt_in,
    input  logic [CH_W-1:0]    ch_sel,
    input  logic               start,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [SUM_W-1:0]   res_sum,
    output logic [HW_W-1:0]    res_mean,
    output logic [HW_W-1:0]    res_min,
    output logic [HW_W-1:0]    res_max,
    output logic [CH_W-1:0]    res_ch
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    localparam logic [LOG_SAMPLES:0] LAST = ((LOG_SAMPLES+1)'(1) << LOG_SAMPLES) - (LOG_SAMPLES+1)'(1);
    localparam logic [HW_W-1:0]      N_HW = HW_W'(N);

    state_t state_q, state_d;

    logic [CH_W-1:0]      ch_q;
    logic [CH_W-1:0]      ch_wrap;
    logic [LOG_SAMPLES:0] cnt_q;
    logic [N-1:0]         words [NCH];
    logic [N-1:0]         sel_word;
    logic [N-1:0]         s1_word_d, s1_word_q;
    logic                 s1_vld_q;
    logic [HW_W-1:0]      s1_hw;
    logic [HW_W-1:0]      s2_hw_q;
    logic                 s2_vld_q;
    logic                 acc_vld_q;     // accumulator absorbed a sample last edge
    logic [SUM_W-1:0]     sum_q;
    logic [HW_W-1:0]      min_q, max_q;
    logic                 accept;
    logic                 launch;
    logic                 finish;

    assign accept  = (state_q == ACC) && en;
    assign launch  = (state_q == IDLE) && start;
    assign finish  = (state_q == DRAIN) && (state_d == DONE);
    assign ch_wrap = CH_W'(int'(ch_sel) % NCH);

    for (genvar g = 0; g < NCH; g++) begin : g_split
        assign words[g] = capt_in[g*N +: N];
    end

    // Select the latched channel's capture word
    always_comb begin
        sel_word = '0;
        for (int c = 0; c < NCH; c++)
            if (ch_q == CH_W'(c)) sel_word = words[c];
    end

`ifdef TDC_BUBBLE_FIX_EN
    logic [N+1:0] ext;
    // Majority vote over neighbours; edges padded as a low-side-filled thermometer
    always_comb begin
        ext = {1'b0, sel_word, 1'b1};
        for (int i = 0; i < N; i++)
            s1_word_d[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
`else
    assign s1_word_d = sel_word;
`endif

    // Hamming weight of the stage-1 word
    always_comb begin
        s1_hw = '0;
        for (int i = 0; i < N; i++) s1_hw = s1_hw + HW_W'(s1_word_q[i]);
    end

    // FSM state register
    always_ff @(posedge clk_capture) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state and status outputs
    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = ACC;
            end
            ACC:   if (accept && cnt_q == LAST) state_d = DRAIN;
            DRAIN: if (!s1_vld_q && !s2_vld_q && !acc_vld_q) state_d = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample pipeline: stage 1 gated by en, stage 2 and tags free-running
    always_ff @(posedge clk_capture) begin
        if (rst) begin
            s1_word_q <= '0;
            s1_vld_q  <= 1'b0;
            s2_hw_q   <= '0;
            s2_vld_q  <= 1'b0;
            acc_vld_q <= 1'b0;
        end else begin
            s1_vld_q  <= accept;
            if (accept) s1_word_q <= s1_word_d;
            s2_hw_q   <= s1_hw;
            s2_vld_q  <= s1_vld_q;
            acc_vld_q <= s2_vld_q;
        end
    end

    // Burst setup, sample counter and sum/min/max accumulation
    always_ff @(posedge clk_capture) begin
        if (rst) begin
            ch_q  <= '0;
            cnt_q <= '0;
            sum_q <= '0;
            min_q <= N_HW;
            max_q <= '0;
        end else if (launch) begin
            ch_q  <= ch_wrap;
            cnt_q <= '0;
            sum_q <= '0;
            min_q <= N_HW;
            max_q <= '0;
        end else begin
            if (accept) cnt_q <= cnt_q + 1'b1;
            if (s2_vld_q) begin
                sum_q <= sum_q + SUM_W'(s2_hw_q);
                if (s2_hw_q < min_q) min_q <= s2_hw_q;
                if (s2_hw_q > max_q) max_q <= s2_hw_q;
            end
        end
    end

    // Result registers load on DONE entry and hold until the next DONE
    always_ff @(posedge clk_capture) begin
        if (rst) begin
            res_sum  <= '0;
            res_mean <= '0;
            res_min  <= '0;
            res_max  <= '0;
            res_ch   <= '0;
        end else if (finish) begin
            res_sum  <= sum_q;
            res_mean <= HW_W'(sum_q >> LOG_SAMPLES);
            res_min  <= min_q;
            res_max  <= max_q;
            res_ch   <= ch_q;
        end
    end

endmodule

// File: tb/tb_tdc_burst_acc.sv
// Scoreboard bench for tdc_burst_acc: stimulus pushes expected results,
// a negedge monitor pops and compares on each res_valid&&res_ready.
module tb_tdc_burst_acc;
    localparam int N    = 64;
    localparam int NCH  = 2;
    localparam int LOG  = 4;
    localparam int HW_W = $clog2(N) + 1;
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW   = HW_W + LOG;

    typedef struct packed {
        logic [SW-1:0]   sum;
        logic [HW_W-1:0] mean;
        logic [HW_W-1:0] mn;
        logic [HW_W-1:0] mx;
        logic [CH_W-1:0] ch;
    } res_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              start = 1'b0;
    logic              res_ready = 1'b1;
    logic [NCH*N-1:0]  capt_in = '0;
    logic [CH_W-1:0]   ch_sel = '0;
    logic              busy, res_valid;
    logic [SW-1:0]     res_sum;
    logic [HW_W-1:0]   res_mean, res_min, res_max;
    logic [CH_W-1:0]   res_ch;

    int   errors = 0;
    int   checks = 0;
    res_t exp_q[$];
    res_t mon_e;

    tdc_burst_acc #(.N(N), .NCH(NCH), .LOG_SAMPLES(LOG)) dut (
        .clk_capture(clk), .rst(rst), .en(en), .capt_in(capt_in), .ch_sel(ch_sel),
        .start(start), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_mean(res_mean), .res_min(res_min), .res_max(res_max),
        .res_ch(res_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [N-1:0] thermo(input int w);
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) if (i < w) r[i] = 1'b1;
        return r;
    endfunction

    // Selected channel carries w; every other channel is all ones
    function automatic logic [NCH*N-1:0] place(input int ch, input logic [N-1:0] w);
        logic [NCH*N-1:0] r = '0;
        for (int c = 0; c < NCH; c++)
            r = r | ((NCH*N)'(c == ch ? w : {N{1'b1}}) << (c*N));
        return r;
    endfunction

    function automatic res_t mk(input int sum, input int mn, input int mx, input int ch);
        res_t r;
        r.sum  = SW'(sum);
        r.mean = HW_W'(sum >> LOG);
        r.mn   = HW_W'(mn);
        r.mx   = HW_W'(mx);
        r.ch   = CH_W'(ch);
        return r;
    endfunction

    // Monitor: one pop per handshake
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum %0d, expected no result", res_sum);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_sum",  res_sum,  mon_e.sum);
                chk("res_mean", res_mean, mon_e.mean);
                chk("res_min",  res_min,  mon_e.mn);
                chk("res_max",  res_max,  mon_e.mx);
                chk("res_ch",   res_ch,   mon_e.ch);
            end
        end
    end

    // One burst: even samples w0, odd samples w1; en_gap starts en low and toggles
    task automatic run_burst(input int ch, input logic [N-1:0] w0, input logic [N-1:0] w1,
                             input bit en_gap, input bit hold, input res_t e);
        int k = 0;
        int c = 0;
        int lows = 0;
        exp_q.push_back(e);
        res_ready = !hold;
        ch_sel = CH_W'(ch);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ch_sel = ~ch_sel;
        chk("busy_after_start", busy, 1);
        while (k < (1 << LOG) && c < 200) begin
            capt_in = place(ch, (k % 2 == 0) ? w0 : w1);
            en = en_gap ? (c % 2 == 1) : 1'b1;
            if (!en) lows++;
            @(posedge clk); #1;
            c++;
            if (en) k++;
        end
        capt_in = '1;
        en = 1'b1;
        while (c < 200) begin
            @(negedge clk);
            if (res_valid) break;
            @(posedge clk); #1;
            c++;
        end
        chk("latency", c, (1 << LOG) + 4 + lows);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                start = (i == 3);
                @(negedge clk);
                chk("hold_valid", res_valid, 1);
                chk("hold_sum",   res_sum,   e.sum);
                chk("hold_min",   res_min,   e.mn);
                chk("hold_max",   res_max,   e.mx);
            end
            @(posedge clk); #1;
            res_ready = 1'b1;
            start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        en = 1'b0;
        @(negedge clk);
        chk("busy_after_handshake",  busy,      0);
        chk("valid_after_handshake", res_valid, 0);
        chk("sum_retained",          res_sum,   e.sum);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        logic [N-1:0] bub;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",  busy,      0);
        chk("rst_valid", res_valid, 0);
        chk("rst_sum",   res_sum,   0);
        chk("rst_mean",  res_mean,  0);
        chk("rst_min",   res_min,   0);
        chk("rst_max",   res_max,   0);
        chk("rst_ch",    res_ch,    0);
        @(posedge clk); #1;

        // Constant 20 ones on channel 1
        run_burst(1, thermo(20), thermo(20), 1'b0, 1'b0, mk(320, 20, 20, 1));
        // Alternating 10/30 on channel 0
        run_burst(0, thermo(10), thermo(30), 1'b0, 1'b0, mk(320, 10, 30, 0));
        // Same with en toggling: identical sum, 16 extra cycles
        run_burst(0, thermo(10), thermo(30), 1'b1, 1'b0, mk(320, 10, 30, 0));
        // Extremes: empty and full words
        run_burst(1, thermo(0), thermo(64), 1'b0, 1'b0, mk(512, 0, 64, 1));
        run_burst(0, thermo(64), thermo(64), 1'b0, 1'b0, mk(1024, 64, 64, 0));
        // Consumer stalls in DONE with a start pulse in between
        run_burst(0, thermo(33), thermo(33), 1'b0, 1'b1, mk(528, 33, 33, 0));

        // Reset after the 7th sample aborts the burst
        ch_sel = 1'b1;
        capt_in = place(1, thermo(20));
        start = 1'b1;
        en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("busy_mid_burst", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        en = 1'b0;
        @(negedge clk);
        chk("abort_busy",  busy,      0);
        chk("abort_valid", res_valid, 0);
        chk("abort_sum",   res_sum,   0);
        chk("abort_mean",  res_mean,  0);
        chk("abort_min",   res_min,   0);
        chk("abort_max",   res_max,   0);
        chk("abort_ch",    res_ch,    0);
        @(posedge clk); #1;
        run_burst(0, thermo(7), thermo(7), 1'b0, 1'b0, mk(112, 7, 7, 0));

        // Thermometer of 20 with a single-bit bubble at bit 5
        bub = thermo(20);
        bub[5] = 1'b0;
`ifdef TDC_BUBBLE_FIX_EN
        run_burst(1, bub, bub, 1'b0, 1'b0, mk(320, 20, 20, 1));
`else
        run_burst(1, bub, bub, 1'b0, 1'b0, mk(304, 19, 19, 1));
`endif

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
